// File: rtl/tmds_decoder.sv
// TMDS receive channel: finds 10-bit symbol alignment from blanking control tokens,
// then decodes aligned symbols to pixel bytes or 2-bit control codes.
module tmds_decoder #(
  parameter int LOCK_COUNT   = 16,
  parameter int SLIP_TIMEOUT = 2048
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] raw_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked_out,
  output logic [3:0] offset_out
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int GAP_W = $clog2(SLIP_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SLIP_TIMEOUT - 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [9:0]       r0, r1, w;
  logic [3:0]       offset, offset_nxt, offset_adv;
  logic [RUN_W-1:0] run, run_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;
  logic             is_token;
  logic [1:0]       code;
  logic [7:0]       d, dec;

  // r0 holds the older word, so the concatenation is in arrival order from bit 0 upward.
  assign w          = 10'({r1, r0} >> offset);
  assign offset_adv = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  always_comb begin
    is_token = 1'b1;
    code     = 2'b00;
    case (w)
      10'b1101010100: code = 2'b00;
      10'b0010101011: code = 2'b01;
      10'b0101010100: code = 2'b10;
      10'b1010101011: code = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain selected by bit 8.
  always_comb begin
    d      = w[9] ? ~w[7:0] : w[7:0];
    dec    = 8'd0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    run_nxt    = run;
    gap_nxt    = gap;
    case (state)
      SEARCH: begin
        if (is_token) begin
          gap_nxt = '0;
          if (run == RUN_LAST) begin
            state_nxt = LOCKED;
            run_nxt   = '0;
          end else begin
            run_nxt = run + RUN_W'(1);
          end
        end else begin
          run_nxt = '0;
          if (gap == GAP_LAST) begin
            offset_nxt = offset_adv;
            gap_nxt    = '0;
          end else begin
            gap_nxt = gap + GAP_W'(1);
          end
        end
      end
      LOCKED: begin
        if (is_token) begin
          gap_nxt = '0;
        end else if (gap == GAP_LAST) begin
          state_nxt  = SEARCH;
          offset_nxt = offset_adv;
          run_nxt    = '0;
          gap_nxt    = '0;
        end else begin
          gap_nxt = gap + GAP_W'(1);
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Output qualification: de_out=1 marks data_out as a pixel byte; with locked_out=1 and
  // de_out=0 ctrl_out carries the control code; with locked_out=0 all payload outputs are 0.
  // Gating uses state_nxt so the symbol that completes the lock is itself emitted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= SEARCH;
      offset   <= 4'd0;
      run      <= '0;
      gap      <= '0;
      r0       <= 10'd0;
      r1       <= 10'd0;
      data_out <= 8'd0;
      ctrl_out <= 2'b00;
      de_out   <= 1'b0;
    end else begin
      state  <= state_nxt;
      offset <= offset_nxt;
      run    <= run_nxt;
      gap    <= gap_nxt;
      r1     <= raw_in;
      r0     <= r1;
      if (state_nxt == LOCKED) begin
        de_out   <= ~is_token;
        data_out <= is_token ? 8'd0 : dec;
        ctrl_out <= is_token ? code : 2'b00;
      end else begin
        de_out   <= 1'b0;
        data_out <= 8'd0;
        ctrl_out <= 2'b00;
      end
    end
  end

  // locked_out is the direct view of the two-state alignment FSM.
  assign locked_out = (state == LOCKED);
  assign offset_out = offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: a bit-stream reference model predicts every output
// cycle; a monitor pops predictions after each rising edge and compares.
`timescale 1ns/1ps
module tb_tmds_decoder;

  localparam int LOCK_N = 16;
  localparam int SLIP_N = 2048;

  logic       clk = 1'b0;
  logic       rst_in;
  logic [9:0] raw_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       locked_out;
  logic [3:0] offset_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] exp_q[$];
  bit          tx_q[$];

  logic [9:0] tok_tab[4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] safe_tab[4] = '{10'h0FF, 10'h300, 10'h3E0, 10'h01F};

  // reference model state
  bit         m_locked;
  int         m_off, m_run, m_gap;
  logic [9:0] m_prev1, m_prev2;

  tmds_decoder dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .raw_in     (raw_in),
    .data_out   (data_out),
    .ctrl_out   (ctrl_out),
    .de_out     (de_out),
    .locked_out (locked_out),
    .offset_out (offset_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // reference model
  function automatic int tok_code(input logic [9:0] w);
    for (int k = 0; k < 4; k++) if (w == tok_tab[k]) return k;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] dd, o;
    dd   = w[9] ? ~w[7:0] : w[7:0];
    o[0] = dd[0];
    for (int i = 1; i < 8; i++) o[i] = dd[i] ^ dd[i-1] ^ ~w[8];
    return o;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_off    = 0;
    m_run    = 0;
    m_gap    = 0;
    m_prev1  = '0;
    m_prev2  = '0;
  endtask

  // Predict the outputs after the edge that captures nw: the window is cut from the two
  // previously sent words, laid out as one bit stream in arrival order.
  task automatic model_step(input logic [9:0] nw);
    bit         s[20];
    logic [9:0] win;
    int         c;
    bit         de_e;
    logic [1:0] ctrl_e;
    logic [7:0] data_e;
    for (int j = 0; j < 10; j++) begin
      s[j]      = m_prev2[j];
      s[j + 10] = m_prev1[j];
    end
    for (int i = 0; i < 10; i++) win[i] = s[m_off + i];
    c = tok_code(win);
    if (!m_locked) begin
      if (c >= 0) begin
        m_gap = 0;
        m_run = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
        if (m_run == LOCK_N) begin
          m_locked = 1;
          m_run    = 0;
          m_gap    = 0;
        end
      end else begin
        m_run = 0;
        m_gap = m_gap + 1;
        if (m_gap == SLIP_N) begin
          m_off = (m_off + 1) % 10;
          m_gap = 0;
        end
      end
    end else begin
      m_gap = (c >= 0) ? 0 : m_gap + 1;
      if (m_gap == SLIP_N) begin
        m_locked = 0;
        m_off    = (m_off + 1) % 10;
        m_run    = 0;
        m_gap    = 0;
      end
    end
    de_e   = m_locked && (c < 0);
    ctrl_e = (m_locked && c >= 0) ? 2'(c) : 2'b00;
    data_e = de_e ? ref_decode(win) : 8'd0;
    exp_q.push_back({m_locked, de_e, ctrl_e, data_e, 4'(m_off)});
    m_prev2 = m_prev1;
    m_prev1 = nw;
  endtask

  // driver tasks
  task automatic send(input logic [9:0] w);
    raw_in = w;
    model_step(w);
    @(negedge clk);
  endtask

  task automatic tx_flush();
    logic [9:0] rw;
    while (tx_q.size() >= 10) begin
      for (int i = 0; i < 10; i++) rw[i] = tx_q.pop_front();
      send(rw);
    end
  endtask

  task automatic tx_sym(input logic [9:0] w);
    for (int i = 0; i < 10; i++) tx_q.push_back(w[i]);
    tx_flush();
  endtask

  task automatic tx_pad(input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(1'b0);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {locked_out, de_out, ctrl_out, data_out, offset_out}, 16'h0000);
  endtask

  // Asynchronous pulse placed inside the low clock phase, away from any edge.
  task automatic async_reset_pulse();
    #1 rst_in = 1'b1;
    #1 check_all_zero("async_reset_outputs");
    exp_q.delete();
    tx_q.delete();
    model_reset();
    #1 rst_in = 1'b0;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [15:0] e, g;
    cyc++;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {locked_out, de_out, ctrl_out, data_out, offset_out};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scoreboard cyc %0d: got lk=%b de=%b ctrl=%b data=%h off=%0d expected lk=%b de=%b ctrl=%b data=%h off=%0d",
                 cyc, g[15], g[14], g[13:12], g[11:4], g[3:0], e[15], e[14], e[13:12], e[11:4], e[3:0]);
      end
    end
  end

  // stimulus
  initial begin
    rst_in = 1'b1;
    raw_in = 10'd0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset_state");
    @(negedge clk);
    rst_in = 1'b0;

    // aligned lock at offset 0, then data decode
    repeat (20) send(10'h354);
    check("t1_locked", {15'd0, locked_out}, 16'd1);
    send(10'h100);
    send(10'h3FF);
    send(10'h0FF);
    repeat (40) send(10'($urandom_range(0, 1023)));

    // all four control tokens while locked
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) send(tok_tab[k]);
    repeat (2) send(10'($urandom_range(0, 1023)));

    // async reset mid-lock, then relock from offset 0
    async_reset_pulse();
    check("t6_offset_after_reset", {12'd0, offset_out}, 16'd0);
    repeat (18) send(10'h354);
    check("t6_relock", {11'd0, locked_out, offset_out}, {11'd0, 1'b1, 4'd0});

    // interrupted run: 15 tokens, one data word, 15 tokens, then 16 more
    async_reset_pulse();
    repeat (15) send(10'h354);
    send(safe_tab[$urandom_range(0, 3)]);
    repeat (15) send(10'h354);
    check("t4_no_lock", {15'd0, locked_out}, 16'd0);
    repeat (16) send(10'h354);
    check("t4_lock", {15'd0, locked_out}, 16'd1);

    // stream misaligned by 3 bits: data long enough for three slips, then tokens
    async_reset_pulse();
    tx_pad(3);
    repeat (6200) tx_sym(safe_tab[$urandom_range(0, 3)]);
    repeat (24) tx_sym(10'h0AB);
    check("t2_lock_offset3", {11'd0, locked_out, offset_out}, {11'd0, 1'b1, 4'd3});

    // lock loss after SLIP_TIMEOUT data words; offset advances
    repeat (SLIP_N + 4) tx_sym(safe_tab[$urandom_range(0, 3)]);
    check("t3_unlock_offset4", {11'd0, locked_out, offset_out}, {11'd0, 1'b0, 4'd4});

    // walk to offset 9, realign the stream there, lock, then lose it and wrap to 0
    repeat (5 * SLIP_N + 20) tx_sym(safe_tab[$urandom_range(0, 3)]);
    tx_pad(6);
    repeat (24) tx_sym(10'h354);
    check("t3_lock_offset9", {11'd0, locked_out, offset_out}, {11'd0, 1'b1, 4'd9});
    repeat (SLIP_N + 4) tx_sym(safe_tab[$urandom_range(0, 3)]);
    check("t3_wrap_offset0", {11'd0, locked_out, offset_out}, {11'd0, 1'b0, 4'd0});

    @(posedge clk);
    #3;
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
